game_renderer: RTL and testbench

GAME_RENDERER -- requirements
Module: game_renderer

---
 rtl/game_renderer_pkg.sv | 56 +++++
 rtl/game_renderer_if.sv | 38 +++
 rtl/game_renderer_block_locator.sv | 43 ++++
 rtl/game_renderer.sv | 143 ++++++++++++++
 tb/tb_game_renderer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/game_renderer_pkg.sv
// ============================================================================
// game_renderer_pkg : shared game geometry, colour types and block palette
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package game_renderer_pkg;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb_t;

  localparam logic [9:0] ballSizePixel     = 10'd8;
  localparam logic [9:0] paddleLengthPixel = 10'd64;
  localparam logic [9:0] paddleHeightPixel = 10'd8;
  localparam logic [9:0] paddleYPixel      = 10'd560;

  localparam logic [9:0] blockStartXPixel  = 10'd16;
  localparam logic [9:0] blockStartYPixel  = 10'd48;
  localparam logic [3:0] blockColCount     = 4'd12;
  localparam logic [2:0] blockRowCount     = 3'd6;
  localparam int         c_blockCount      = 72;

  // Wall positions are in 8-pixel tiles
  localparam logic [6:0] leftWallXTile     = 7'd1;
  localparam logic [6:0] rightWallXTile    = 7'd98;
  localparam logic [6:0] ceilingYTile      = 7'd4;

  localparam rgb_t c_colourBlack   = '{r: 3'd0, g: 3'd0, b: 2'd0};
  localparam rgb_t c_colourLost    = '{r: 3'd2, g: 3'd0, b: 2'd0};
  localparam rgb_t c_colourBall    = '{r: 3'd7, g: 3'd7, b: 2'd3};
  localparam rgb_t c_colourPaddle  = '{r: 3'd0, g: 3'd7, b: 2'd3};
  localparam rgb_t c_colourWall    = '{r: 3'd4, g: 3'd4, b: 2'd2};
  localparam rgb_t c_colourRed     = '{r: 3'd7, g: 3'd0, b: 2'd0};
  localparam rgb_t c_colourOrange  = '{r: 3'd7, g: 3'd3, b: 2'd0};
  localparam rgb_t c_colourYellow  = '{r: 3'd7, g: 3'd7, b: 2'd0};
  localparam rgb_t c_colourGreen   = '{r: 3'd0, g: 3'd7, b: 2'd0};
  localparam rgb_t c_colourBlue    = '{r: 3'd0, g: 3'd0, b: 2'd3};
  localparam rgb_t c_colourMagenta = '{r: 3'd7, g: 3'd0, b: 2'd3};

  function automatic rgb_t block_colour(input logic [2:0] row);
    case (row)
      3'd0:    block_colour = c_colourRed;
      3'd1:    block_colour = c_colourOrange;
      3'd2:    block_colour = c_colourYellow;
      3'd3:    block_colour = c_colourGreen;
      3'd4:    block_colour = c_colourBlue;
      default: block_colour = c_colourMagenta;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/game_renderer_if.sv
// ============================================================================
// game_renderer_if : raster, physics and colour signals of the renderer
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

interface game_renderer_if;
  import game_renderer_pkg::*;

  logic [9:0]              PIXEL_X;
  logic [9:0]              PIXEL_Y;
  logic                    PIXEL_ACTIVE;
  logic                    FRAME_END;
  logic [9:0]              PADDLE_X_PIXEL;
  logic [9:0]              BALL_X_PIXEL;
  logic [9:0]              BALL_Y_PIXEL;
  logic [c_blockCount-1:0] BLOCK_STATE;
  logic                    BALL_LOST;
  logic [2:0]              RED;
  logic [2:0]              GREEN;
  logic [1:0]              BLUE;
  logic                    START_UPDATE;

  modport master (
    output PIXEL_X, PIXEL_Y, PIXEL_ACTIVE, FRAME_END,
    output PADDLE_X_PIXEL, BALL_X_PIXEL, BALL_Y_PIXEL, BLOCK_STATE, BALL_LOST,
    input  RED, GREEN, BLUE, START_UPDATE
  );

  modport slave (
    input  PIXEL_X, PIXEL_Y, PIXEL_ACTIVE, FRAME_END,
    input  PADDLE_X_PIXEL, BALL_X_PIXEL, BALL_Y_PIXEL, BLOCK_STATE, BALL_LOST,
    output RED, GREEN, BLUE, START_UPDATE
  );

endinterface

`default_nettype wire

// File: rtl/game_renderer_block_locator.sv
// ============================================================================
// block_locator : maps a pixel onto block row / flat index, excluding the gap
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module block_locator
  import game_renderer_pkg::*;
#(
  parameter int BLOCK_GAP = 1
) (
  input  wire  [9:0] i_x,
  input  wire  [9:0] i_y,
  output logic [2:0] o_row,
  output logic [6:0] o_index,
  output logic       o_valid
);

  localparam int c_gapX = 64 - BLOCK_GAP;
  localparam int c_gapY = 16 - BLOCK_GAP;

  logic [9:0] w_dx;
  logic [9:0] w_dy;
  logic [3:0] w_col;
  logic       w_in_x;
  logic       w_in_y;
  logic       w_gap;

  // Explicit lower-bound checks stop wrapped offsets from landing on a block
  assign w_dx   = i_x - blockStartXPixel;
  assign w_dy   = i_y - blockStartYPixel;
  assign w_col  = w_dx[9:6];
  assign w_in_x = (i_x >= blockStartXPixel) && (w_col < blockColCount);
  assign w_in_y = (i_y >= blockStartYPixel) && (w_dy[9:4] < {3'd0, blockRowCount});
  assign w_gap  = (int'(w_dx[5:0]) >= c_gapX) || (int'(w_dy[3:0]) >= c_gapY);

  assign o_row   = w_dy[6:4];
  assign o_index = ({4'd0, o_row} * {3'd0, blockColCount}) + {3'd0, w_col};
  assign o_valid = w_in_x && w_in_y && !w_gap;

endmodule

`default_nettype wire

// File: rtl/game_renderer.sv
// ============================================================================
// game_renderer : 2-cycle pixel colour pipeline over a per-frame snapshot
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module game_renderer
  import game_renderer_pkg::*;
#(
  parameter int BLOCK_GAP = 1
) (
  input  wire              CLK,
  input  wire              RESET,
  game_renderer_if.slave   bus
);

  logic [9:0]              r_pend_paddle_x, r_pend_ball_x, r_pend_ball_y;
  logic [c_blockCount-1:0] r_pend_blocks;
  logic                    r_pend_lost, r_pend_vld;
  logic [9:0]              r_snap_paddle_x, r_snap_ball_x, r_snap_ball_y;
  logic [c_blockCount-1:0] r_snap_blocks;
  logic                    r_snap_lost;
  logic                    r_start;
  logic [9:0]              r_s1_x, r_s1_y;
  logic                    r_s1_act;
  rgb_t                    r_rgb;

  // Physics values are captured on FRAME_END and published one cycle later,
  // so a pixel coincident with FRAME_END still sees the previous snapshot.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_pend_paddle_x <= '0;
      r_pend_ball_x   <= '0;
      r_pend_ball_y   <= '0;
      r_pend_blocks   <= '0;
      r_pend_lost     <= 1'b0;
      r_pend_vld      <= 1'b0;
      r_snap_paddle_x <= '0;
      r_snap_ball_x   <= '0;
      r_snap_ball_y   <= '0;
      r_snap_blocks   <= '0;
      r_snap_lost     <= 1'b0;
      r_start         <= 1'b0;
    end else begin
      r_pend_vld <= bus.FRAME_END;
      r_start    <= bus.FRAME_END;
      if (bus.FRAME_END) begin
        r_pend_paddle_x <= bus.PADDLE_X_PIXEL;
        r_pend_ball_x   <= bus.BALL_X_PIXEL;
        r_pend_ball_y   <= bus.BALL_Y_PIXEL;
        r_pend_blocks   <= bus.BLOCK_STATE;
        r_pend_lost     <= bus.BALL_LOST;
      end
      if (r_pend_vld) begin
        r_snap_paddle_x <= r_pend_paddle_x;
        r_snap_ball_x   <= r_pend_ball_x;
        r_snap_ball_y   <= r_pend_ball_y;
        r_snap_blocks   <= r_pend_blocks;
        r_snap_lost     <= r_pend_lost;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_s1_x   <= '0;
      r_s1_y   <= '0;
      r_s1_act <= 1'b0;
    end else begin
      r_s1_x   <= bus.PIXEL_X;
      r_s1_y   <= bus.PIXEL_Y;
      r_s1_act <= bus.PIXEL_ACTIVE;
    end
  end

  logic [10:0] w_x11, w_y11;
  logic        w_hit_ball, w_hit_paddle, w_hit_block, w_hit_wall;
  logic [2:0]  w_loc_row;
  logic [6:0]  w_loc_index;
  logic        w_loc_valid;
  rgb_t        w_colour;

  block_locator #(
    .BLOCK_GAP (BLOCK_GAP)
  ) u_block_locator (
    .i_x     (r_s1_x),
    .i_y     (r_s1_y),
    .o_row   (w_loc_row),
    .o_index (w_loc_index),
    .o_valid (w_loc_valid)
  );

  // 11-bit compares: ball pixels past the 10-bit wrap are simply not drawn
  assign w_x11 = {1'b0, r_s1_x};
  assign w_y11 = {1'b0, r_s1_y};

  assign w_hit_ball =
      (w_x11 >= {1'b0, r_snap_ball_x}) &&
      (w_x11 <  ({1'b0, r_snap_ball_x} + {1'b0, ballSizePixel})) &&
      (w_y11 >= {1'b0, r_snap_ball_y}) &&
      (w_y11 <  ({1'b0, r_snap_ball_y} + {1'b0, ballSizePixel}));

  assign w_hit_paddle =
      (w_x11 >= {1'b0, r_snap_paddle_x}) &&
      (w_x11 <  ({1'b0, r_snap_paddle_x} + {1'b0, paddleLengthPixel})) &&
      (w_y11 >= {1'b0, paddleYPixel}) &&
      (w_y11 <  ({1'b0, paddleYPixel} + {1'b0, paddleHeightPixel}));

  assign w_hit_block = w_loc_valid && r_snap_blocks[w_loc_index];

  assign w_hit_wall = (r_s1_x[9:3] == leftWallXTile)  ||
                      (r_s1_x[9:3] == rightWallXTile) ||
                      (r_s1_y[9:3] == ceilingYTile);

  always_comb begin
    w_colour = r_snap_lost ? c_colourLost : c_colourBlack;
    if (w_hit_ball) begin
      w_colour = c_colourBall;
    end else if (w_hit_paddle) begin
      w_colour = c_colourPaddle;
    end else if (w_hit_block) begin
      w_colour = block_colour(w_loc_row);
    end else if (w_hit_wall) begin
      w_colour = c_colourWall;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_rgb <= c_colourBlack;
    end else begin
      r_rgb <= r_s1_act ? w_colour : c_colourBlack;
    end
  end

  assign bus.RED          = r_rgb.r;
  assign bus.GREEN        = r_rgb.g;
  assign bus.BLUE         = r_rgb.b;
  assign bus.START_UPDATE = r_start;

endmodule

`default_nettype wire

// File: tb/tb_game_renderer.sv
// ============================================================================
// tb_game_renderer : directed self-checking bench for game_renderer
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_renderer;

  localparam logic [7:0] c_black   = 8'h00;
  localparam logic [7:0] c_white   = 8'hFF;
  localparam logic [7:0] c_cyan    = 8'h1F;
  localparam logic [7:0] c_grey    = 8'h92;
  localparam logic [7:0] c_red     = 8'hE0;
  localparam logic [7:0] c_orange  = 8'hEC;
  localparam logic [7:0] c_darkred = 8'h40;
  localparam logic [71:0] c_all    = {72{1'b1}};
  localparam logic [71:0] c_no13   = ~(72'd1 << 13);

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  game_renderer_if bus ();

  game_renderer #(
    .BLOCK_GAP (1)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  function automatic logic [7:0] rgb_now();
    return {bus.RED, bus.GREEN, bus.BLUE};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pixel is presented for one cycle only, so the result must appear exactly
  // two edges later; a shorter pipeline would show the parked blank pixel.
  task automatic px(input string tag, input int x, input int y, input logic act,
                    input logic [7:0] exp);
    bus.PIXEL_X      = 10'(x);
    bus.PIXEL_Y      = 10'(y);
    bus.PIXEL_ACTIVE = act;
    @(posedge clk); #1;
    bus.PIXEL_X      = '0;
    bus.PIXEL_Y      = '0;
    bus.PIXEL_ACTIVE = 1'b0;
    @(posedge clk); #1;
    chk(tag, rgb_now(), exp);
  endtask

  task automatic frame(input int pad, input int bx, input int by,
                       input logic [71:0] blk, input logic lost);
    bus.PADDLE_X_PIXEL = 10'(pad);
    bus.BALL_X_PIXEL   = 10'(bx);
    bus.BALL_Y_PIXEL   = 10'(by);
    bus.BLOCK_STATE    = blk;
    bus.BALL_LOST      = lost;
    chk("start_before_fe", {7'd0, bus.START_UPDATE}, 8'd0);
    bus.FRAME_END = 1'b1;
    @(posedge clk); #1;
    bus.FRAME_END = 1'b0;
    chk("start_pulse", {7'd0, bus.START_UPDATE}, 8'd1);
    @(posedge clk); #1;
    chk("start_one_cycle", {7'd0, bus.START_UPDATE}, 8'd0);
  endtask

  initial begin
    rst                = 1'b1;
    bus.PIXEL_X        = 10'd395;
    bus.PIXEL_Y        = 10'd400;
    bus.PIXEL_ACTIVE   = 1'b1;
    bus.FRAME_END      = 1'b1;
    bus.PADDLE_X_PIXEL = 10'd370;
    bus.BALL_X_PIXEL   = 10'd395;
    bus.BALL_Y_PIXEL   = 10'd400;
    bus.BLOCK_STATE    = c_all;
    bus.BALL_LOST      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rgb", rgb_now(), c_black);
    chk("reset_start", {7'd0, bus.START_UPDATE}, 8'd0);
    bus.FRAME_END    = 1'b0;
    bus.PIXEL_ACTIVE = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Snapshot still empty after reset: no blocks, no lost tint; walls draw
    px("pre_snap_block", 16, 48, 1'b1, c_black);
    px("pre_snap_wall", 8, 100, 1'b1, c_grey);

    frame(370, 395, 400, c_all, 1'b0);
    px("block_r0c0", 16, 48, 1'b1, c_red);
    px("ball_origin", 395, 400, 1'b1, c_white);
    px("ball_corner", 402, 407, 1'b1, c_white);
    px("ball_right_out", 403, 400, 1'b1, c_black);
    px("ball_left_out", 394, 400, 1'b1, c_black);
    px("inactive", 395, 400, 1'b0, c_black);
    px("left_wall", 10, 300, 1'b1, c_grey);
    px("right_wall", 786, 5, 1'b1, c_grey);
    px("ceiling", 400, 35, 1'b1, c_grey);
    px("block_r1c0", 16, 64, 1'b1, c_orange);
    px("block_r0_gap_y", 16, 63, 1'b1, c_black);
    px("block_c11", 782, 48, 1'b1, c_red);
    px("block_c11_gap", 783, 48, 1'b1, c_black);
    px("below_blocks", 16, 144, 1'b1, c_black);
    px("above_blocks", 300, 47, 1'b1, c_black);

    frame(370, 380, 556, c_all, 1'b0);
    px("ball_over_paddle", 380, 560, 1'b1, c_white);
    px("paddle_corner", 433, 563, 1'b1, c_cyan);
    px("paddle_left_bot", 370, 567, 1'b1, c_cyan);
    px("paddle_right_out", 434, 560, 1'b1, c_black);
    px("paddle_left_out", 369, 560, 1'b1, c_black);
    px("paddle_below", 433, 568, 1'b1, c_black);

    frame(370, 500, 300, c_no13, 1'b0);
    px("cleared_block", 80, 64, 1'b1, c_black);
    px("gap_x", 79, 64, 1'b1, c_black);
    px("block_r1c0_b", 78, 64, 1'b1, c_orange);
    px("block_r1c2", 144, 64, 1'b1, c_orange);
    px("gap_corner", 143, 79, 1'b1, c_black);

    // Live ball moves without FRAME_END: picture must not follow it
    bus.BALL_X_PIXEL = 10'd600;
    px("hold_old_ball", 500, 300, 1'b1, c_white);
    px("hold_new_ball", 600, 300, 1'b1, c_black);
    frame(370, 600, 300, c_no13, 1'b0);
    px("moved_new_ball", 600, 300, 1'b1, c_white);
    px("moved_old_ball", 500, 300, 1'b1, c_black);

    // Pixel coincident with FRAME_END uses the outgoing snapshot
    bus.BALL_X_PIXEL = 10'd700;
    bus.FRAME_END    = 1'b1;
    bus.PIXEL_X      = 10'd600;
    bus.PIXEL_Y      = 10'd300;
    bus.PIXEL_ACTIVE = 1'b1;
    @(posedge clk); #1;
    bus.FRAME_END = 1'b0;
    bus.PIXEL_X   = 10'd700;
    chk("coincide_start", {7'd0, bus.START_UPDATE}, 8'd1);
    @(posedge clk); #1;
    bus.PIXEL_ACTIVE = 1'b0;
    chk("coincide_old_snap", rgb_now(), c_white);
    @(posedge clk); #1;
    chk("after_new_snap", rgb_now(), c_white);
    @(posedge clk); #1;

    frame(370, 1020, 300, c_all, 1'b1);
    px("ball_wrap_first", 1020, 300, 1'b1, c_white);
    px("ball_wrap_last", 1023, 300, 1'b1, c_white);
    px("ball_wrap_x0", 0, 300, 1'b1, c_darkred);
    px("ball_wrap_x3", 3, 300, 1'b1, c_darkred);
    px("lost_background", 300, 300, 1'b1, c_darkred);
    px("lost_inactive", 300, 300, 1'b0, c_black);

    // Mid-line reset with a START_UPDATE pulse in flight
    bus.PIXEL_X      = 10'd300;
    bus.PIXEL_Y      = 10'd300;
    bus.PIXEL_ACTIVE = 1'b1;
    bus.FRAME_END    = 1'b1;
    @(posedge clk); #1;
    bus.FRAME_END = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_rgb", rgb_now(), c_darkred);
    @(posedge clk); #1;
    bus.FRAME_END = 1'b1;
    @(posedge clk); #1;
    bus.FRAME_END = 1'b0;
    chk("pre_reset_start", {7'd0, bus.START_UPDATE}, 8'd1);
    #2 rst = 1'b1;
    #1;
    chk("midline_reset_rgb", rgb_now(), c_black);
    chk("midline_reset_start", {7'd0, bus.START_UPDATE}, 8'd0);
    @(posedge clk); #1;
    chk("reset_held_rgb", rgb_now(), c_black);
    rst = 1'b0;
    bus.PIXEL_ACTIVE = 1'b0;
    @(posedge clk); #1;
    px("post_reset_no_blocks", 16, 48, 1'b1, c_black);
    px("post_reset_no_lost", 300, 300, 1'b1, c_black);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
